// File: rtl/rs_enc_udp_pkg.sv
// Shared definitions for the RS encoder response depacketizer.
//   - NoC / header field widths and the accepted fbits value
//   - beehive_noc_hdr_flit: field layout of the header flit
//   - depkt_state_e: depacketizer FSM states
//   - meta_load(): number of metadata flits actually stripped
package rs_enc_udp_pkg;

  localparam int NOC_DATA_WIDTH   = 64;
  localparam int XY_WIDTH         = 8;
  localparam int MSG_LENGTH_WIDTH = 8;
  localparam int MSG_TYPE_WIDTH   = 8;
  localparam int FBITS_WIDTH      = 4;
  localparam int DEF_MAX_META     = 4;

  localparam logic [FBITS_WIDTH-1:0] PKT_IF_FBITS = 4'hA;

  // Header flit layout, MSB first (64 bits total).
  typedef struct packed {
    logic [XY_WIDTH-1:0]         dst_x;
    logic [XY_WIDTH-1:0]         dst_y;
    logic [FBITS_WIDTH-1:0]      dst_fbits;
    logic [MSG_LENGTH_WIDTH-1:0] msg_len;
    logic [MSG_TYPE_WIDTH-1:0]   msg_type;
    logic [MSG_LENGTH_WIDTH-1:0] metadata_flits;
    logic [XY_WIDTH-1:0]         src_x;
    logic [XY_WIDTH-1:0]         src_y;
    logic [3:0]                  pad;
  } beehive_noc_hdr_flit;

  typedef enum logic [2:0] {
    HDR,
    HDR_OUT,
    META,
    DATA,
    DROP
  } depkt_state_e;

  // Metadata flits stripped = min(metadata_flits, msg_len, cap). Anything
  // above the cap stays in the payload stream.
  function automatic logic [MSG_LENGTH_WIDTH-1:0] meta_load(
    input logic [MSG_LENGTH_WIDTH-1:0] msg_len,
    input logic [MSG_LENGTH_WIDTH-1:0] meta_flits,
    input logic [MSG_LENGTH_WIDTH-1:0] cap
  );
    logic [MSG_LENGTH_WIDTH-1:0] m;
    m = msg_len;
    if (meta_flits < m) m = meta_flits;
    if (cap < m) m = cap;
    return m;
  endfunction

endpackage

// File: rtl/rs_enc_resp_depacketizer_if.sv
// Signal bundle for the depacketizer's NoC input, header record output and
// payload output.
//   master: flit producer / record consumer side (drives noc_in_*, *_rdy)
//   slave : depacketizer side
interface rs_enc_resp_depacketizer_if;
  import rs_enc_udp_pkg::*;

  logic                        noc_in_val;
  logic [NOC_DATA_WIDTH-1:0]   noc_in_data;
  logic                        noc_in_rdy;

  logic                        hdr_out_val;
  logic [XY_WIDTH-1:0]         hdr_out_src_x;
  logic [XY_WIDTH-1:0]         hdr_out_src_y;
  logic [MSG_LENGTH_WIDTH-1:0] hdr_out_len;
  logic                        hdr_out_rdy;

  logic                        data_out_val;
  logic [NOC_DATA_WIDTH-1:0]   data_out_data;
  logic                        data_out_last;
  logic                        data_out_rdy;

  modport master (
    output noc_in_val, noc_in_data, hdr_out_rdy, data_out_rdy,
    input  noc_in_rdy, hdr_out_val, hdr_out_src_x, hdr_out_src_y, hdr_out_len,
    input  data_out_val, data_out_data, data_out_last
  );

  modport slave (
    input  noc_in_val, noc_in_data, hdr_out_rdy, data_out_rdy,
    output noc_in_rdy, hdr_out_val, hdr_out_src_x, hdr_out_src_y, hdr_out_len,
    output data_out_val, data_out_data, data_out_last
  );

endinterface

// File: rtl/rs_enc_resp_hdr_reg.sv
// Header capture register and hdr_out handshake.
//   cap_en/cap_*  : load source coordinates and length from the header flit
//   show          : present the record (FSM is in HDR_OUT)
//   hdr_out_*     : record output, fields come straight from the registers
//   hdr_fire      : record handshake this cycle
module rs_enc_resp_hdr_reg
  import rs_enc_udp_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cap_en,
  input  logic [XY_WIDTH-1:0]         cap_src_x,
  input  logic [XY_WIDTH-1:0]         cap_src_y,
  input  logic [MSG_LENGTH_WIDTH-1:0] cap_len,
  input  logic                        show,
  output logic                        hdr_out_val,
  output logic [XY_WIDTH-1:0]         hdr_out_src_x,
  output logic [XY_WIDTH-1:0]         hdr_out_src_y,
  output logic [MSG_LENGTH_WIDTH-1:0] hdr_out_len,
  input  logic                        hdr_out_rdy,
  output logic                        hdr_fire
);

  logic [XY_WIDTH-1:0]         src_x_q, src_x_d;
  logic [XY_WIDTH-1:0]         src_y_q, src_y_d;
  logic [MSG_LENGTH_WIDTH-1:0] len_q, len_d;

  // Capture only happens in HDR, so the fields cannot move while the
  // record is being offered.
  always_comb begin
    src_x_d = src_x_q;
    src_y_d = src_y_q;
    len_d   = len_q;
    if (cap_en) begin
      src_x_d = cap_src_x;
      src_y_d = cap_src_y;
      len_d   = cap_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_x_q <= '0;
      src_y_q <= '0;
      len_q   <= '0;
    end else begin
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      len_q   <= len_d;
    end
  end

  assign hdr_out_val   = show;
  assign hdr_fire      = show & hdr_out_rdy;
  assign hdr_out_src_x = src_x_q;
  assign hdr_out_src_y = src_y_q;
  assign hdr_out_len   = len_q;

endmodule

// File: rtl/rs_enc_resp_depacketizer.sv
// Splits NoC response packets into a header record and a payload stream.
//   noc_in_*   : flit input (val/rdy); first flit of a packet is the header
//   hdr_out_*  : one record per accepted packet (src_x, src_y, msg_len)
//   data_out_* : payload flits, combinational pass-through, last on final flit
//   pkt_cnt    : accepted packets, drop_cnt: packets rejected on fbits
// Packets with unexpected fbits are consumed silently. Up to MAX_META
// leading metadata flits are stripped from the payload.
module rs_enc_resp_depacketizer
  import rs_enc_udp_pkg::*;
#(
  parameter logic [FBITS_WIDTH-1:0] EXP_FBITS = PKT_IF_FBITS,
  parameter int                     MAX_META  = DEF_MAX_META
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        noc_in_val,
  input  logic [NOC_DATA_WIDTH-1:0]   noc_in_data,
  output logic                        noc_in_rdy,
  output logic                        hdr_out_val,
  output logic [XY_WIDTH-1:0]         hdr_out_src_x,
  output logic [XY_WIDTH-1:0]         hdr_out_src_y,
  output logic [MSG_LENGTH_WIDTH-1:0] hdr_out_len,
  input  logic                        hdr_out_rdy,
  output logic                        data_out_val,
  output logic [NOC_DATA_WIDTH-1:0]   data_out_data,
  output logic                        data_out_last,
  input  logic                        data_out_rdy,
  output logic [31:0]                 pkt_cnt,
  output logic [31:0]                 drop_cnt
);

  localparam logic [MSG_LENGTH_WIDTH-1:0] LEN_ONE  = MSG_LENGTH_WIDTH'(1);
  localparam logic [MSG_LENGTH_WIDTH-1:0] META_CAP = MSG_LENGTH_WIDTH'(MAX_META);

  depkt_state_e                state_q, state_d;
  logic [MSG_LENGTH_WIDTH-1:0] rem_q, rem_d;    // flits left after header
  logic [MSG_LENGTH_WIDTH-1:0] meta_q, meta_d;  // metadata flits left to strip
  logic [31:0]                 pkt_cnt_q, pkt_cnt_d;
  logic [31:0]                 drop_cnt_q, drop_cnt_d;

  beehive_noc_hdr_flit hdr_flit;
  logic                hdr_cap, hdr_show, hdr_fire;
  logic                unused_hdr_bits;

  assign hdr_flit        = noc_in_data;
  assign unused_hdr_bits = ^{hdr_flit.dst_x, hdr_flit.dst_y, hdr_flit.msg_type, hdr_flit.pad};

  rs_enc_resp_hdr_reg u_hdr_reg (
    .clk          (clk),
    .rst          (rst),
    .cap_en       (hdr_cap),
    .cap_src_x    (hdr_flit.src_x),
    .cap_src_y    (hdr_flit.src_y),
    .cap_len      (hdr_flit.msg_len),
    .show         (hdr_show),
    .hdr_out_val  (hdr_out_val),
    .hdr_out_src_x(hdr_out_src_x),
    .hdr_out_src_y(hdr_out_src_y),
    .hdr_out_len  (hdr_out_len),
    .hdr_out_rdy  (hdr_out_rdy),
    .hdr_fire     (hdr_fire)
  );

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    meta_d        = meta_q;
    pkt_cnt_d     = pkt_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    noc_in_rdy    = 1'b0;
    data_out_val  = 1'b0;
    data_out_last = 1'b0;
    hdr_cap       = 1'b0;
    hdr_show      = 1'b0;

    case (state_q)
      HDR: begin
        noc_in_rdy = 1'b1;
        if (noc_in_val) begin
          hdr_cap = 1'b1;
          rem_d   = hdr_flit.msg_len;
          meta_d  = meta_load(hdr_flit.msg_len, hdr_flit.metadata_flits, META_CAP);
          if (hdr_flit.dst_fbits != EXP_FBITS) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            // A bodiless bad header needs no DROP pass; stay ready.
            if (hdr_flit.msg_len != '0) state_d = DROP;
          end else begin
            state_d = HDR_OUT;
          end
        end
      end

      HDR_OUT: begin
        hdr_show = 1'b1;
        if (hdr_fire) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          if (meta_q != '0)     state_d = META;
          else if (rem_q != '0) state_d = DATA;
          else                  state_d = HDR;
        end
      end

      META: begin
        noc_in_rdy = 1'b1;
        if (noc_in_val) begin
          meta_d = meta_q - LEN_ONE;
          rem_d  = rem_q - LEN_ONE;
          // meta never exceeds rem, so rem hits 0 here only if both were 1.
          if (meta_q == LEN_ONE) state_d = (rem_q == LEN_ONE) ? HDR : DATA;
        end
      end

      DATA: begin
        data_out_val  = noc_in_val;
        noc_in_rdy    = data_out_rdy;
        data_out_last = (rem_q == LEN_ONE);
        if (noc_in_val && data_out_rdy) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = HDR;
        end
      end

      DROP: begin
        noc_in_rdy = 1'b1;
        if (noc_in_val) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = HDR;
        end
      end

      default: state_d = HDR;
    endcase

    // The NoC is reset alongside us; keep the input open and outputs quiet
    // even before the state register has settled.
    if (rst) begin
      noc_in_rdy   = 1'b1;
      data_out_val = 1'b0;
      hdr_show     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR;
      rem_q      <= '0;
      meta_q     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      meta_q     <= meta_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign data_out_data = noc_in_data;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rs_enc_resp_depacketizer.sv
module tb_rs_enc_resp_depacketizer;
  import rs_enc_udp_pkg::*;

  localparam int MAXM = DEF_MAX_META;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_cnt, drop_cnt;

  always #5 clk = ~clk;

  rs_enc_resp_depacketizer_if bus();

  rs_enc_resp_depacketizer dut (
    .clk          (clk),
    .rst          (rst),
    .noc_in_val   (bus.noc_in_val),
    .noc_in_data  (bus.noc_in_data),
    .noc_in_rdy   (bus.noc_in_rdy),
    .hdr_out_val  (bus.hdr_out_val),
    .hdr_out_src_x(bus.hdr_out_src_x),
    .hdr_out_src_y(bus.hdr_out_src_y),
    .hdr_out_len  (bus.hdr_out_len),
    .hdr_out_rdy  (bus.hdr_out_rdy),
    .data_out_val (bus.data_out_val),
    .data_out_data(bus.data_out_data),
    .data_out_last(bus.data_out_last),
    .data_out_rdy (bus.data_out_rdy),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt)
  );

  typedef struct { logic [7:0] sx; logic [7:0] sy; logic [7:0] len; } hdr_rec_t;
  typedef struct { logic [63:0] d; logic last; } beat_t;
  typedef struct { bit ok; int len; int meta; int hdrs; int beats; int dpkt; int ddrop; } vec_t;

  logic [63:0] tx_q[$];
  hdr_rec_t    exp_hdr[$];
  beat_t       exp_beat[$];
  int          noc_cyc[$], hdr_cyc[$];
  vec_t        tbl[$];

  int n_chk = 0, n_pass = 0, cyc = 0;
  int hdr_seen, beat_seen, noc_seen;
  int val_pct = 100, hrdy_pct = 100, drdy_pct = 100;
  bit       hold_v = 1'b0;
  hdr_rec_t hold_r;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Reference model: builds the flit stream and the outputs the packet
  // must produce, straight from the packet format rules.
  task automatic add_pkt(bit ok, int len, int meta);
    beehive_noc_hdr_flit h;
    hdr_rec_t r;
    beat_t    b;
    logic [63:0] f;
    int m;
    h = '0;
    h.dst_x          = 8'($urandom);
    h.dst_y          = 8'($urandom);
    h.dst_fbits      = ok ? PKT_IF_FBITS : (PKT_IF_FBITS ^ 4'($urandom_range(15, 1)));
    h.msg_len        = 8'(len);
    h.msg_type       = 8'($urandom);
    h.metadata_flits = 8'(meta);
    h.src_x          = 8'($urandom);
    h.src_y          = 8'($urandom);
    tx_q.push_back(h);
    m = meta;
    if (len < m) m = len;
    if (MAXM < m) m = MAXM;
    if (ok) begin
      r.sx = h.src_x; r.sy = h.src_y; r.len = h.msg_len;
      exp_hdr.push_back(r);
    end
    for (int i = 0; i < len; i++) begin
      f = {$urandom, $urandom};
      tx_q.push_back(f);
      if (ok && i >= m) begin
        b.d = f; b.last = (i == len - 1);
        exp_beat.push_back(b);
      end
    end
  endtask

  // One cycle: drive at negedge, sample 1 time unit before the posedge.
  task automatic step();
    hdr_rec_t r;
    beat_t    b;
    @(negedge clk);
    cyc++;
    bus.noc_in_val   = (tx_q.size() > 0) && ($urandom_range(99) < val_pct);
    bus.noc_in_data  = bus.noc_in_val ? tx_q[0] : {$urandom, $urandom};
    bus.hdr_out_rdy  = ($urandom_range(99) < hrdy_pct);
    bus.data_out_rdy = ($urandom_range(99) < drdy_pct);
    #4;
    if (hold_v) begin
      chk("hdr_hold_val", 64'(bus.hdr_out_val), 64'd1);
      chk("hdr_hold_fields", 64'({bus.hdr_out_src_x, bus.hdr_out_src_y, bus.hdr_out_len}),
          64'({hold_r.sx, hold_r.sy, hold_r.len}));
    end
    hold_v    = bus.hdr_out_val && !bus.hdr_out_rdy;
    hold_r.sx = bus.hdr_out_src_x; hold_r.sy = bus.hdr_out_src_y; hold_r.len = bus.hdr_out_len;
    if (bus.noc_in_val && bus.noc_in_rdy) begin
      void'(tx_q.pop_front());
      noc_seen++;
      noc_cyc.push_back(cyc);
    end
    if (bus.hdr_out_val && bus.hdr_out_rdy) begin
      hdr_seen++;
      hdr_cyc.push_back(cyc);
      if (exp_hdr.size() == 0) chk("hdr_unexpected", 64'd1, 64'd0);
      else begin
        r = exp_hdr.pop_front();
        chk("hdr_fields", 64'({bus.hdr_out_src_x, bus.hdr_out_src_y, bus.hdr_out_len}),
            64'({r.sx, r.sy, r.len}));
      end
    end
    if (bus.data_out_val && bus.data_out_rdy) begin
      beat_seen++;
      if (exp_beat.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
      else begin
        b = exp_beat.pop_front();
        chk("beat_data", bus.data_out_data, b.d);
        chk("beat_last", 64'(bus.data_out_last), 64'(b.last));
      end
    end
  endtask

  task automatic run_idle(string nm, int budget);
    int n = 0;
    while ((tx_q.size() > 0 || exp_hdr.size() > 0 || exp_beat.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_drain"}, 64'(tx_q.size() + exp_hdr.size() + exp_beat.size()), 64'd0);
    step();
    step();
  endtask

  task automatic do_reset(string nm, int n);
    @(negedge clk);
    rst = 1'b1;
    bus.noc_in_val   = 1'b0;
    bus.hdr_out_rdy  = 1'b1;
    bus.data_out_rdy = 1'b1;
    tx_q.delete(); exp_hdr.delete(); exp_beat.delete();
    hold_v = 1'b0;
    #4;
    chk({nm, "_in_rst_rdy"}, 64'(bus.noc_in_rdy), 64'd1);
    chk({nm, "_in_rst_hval"}, 64'(bus.hdr_out_val), 64'd0);
    chk({nm, "_in_rst_dval"}, 64'(bus.data_out_val), 64'd0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
    chk({nm, "_post_rdy"}, 64'(bus.noc_in_rdy), 64'd1);
    chk({nm, "_post_vals"}, 64'({bus.hdr_out_val, bus.data_out_val}), 64'd0);
    chk({nm, "_post_cnts"}, {pkt_cnt, drop_cnt}, 64'd0);
    chk({nm, "_post_hdr"}, 64'({bus.hdr_out_src_x, bus.hdr_out_src_y, bus.hdr_out_len}), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] p0, d0;
    bus.noc_in_val = 1'b0; bus.noc_in_data = '0;
    bus.hdr_out_rdy = 1'b0; bus.data_out_rdy = 1'b0;

    do_reset("init", 3);

    // ok, len, meta, hdr records, data beats, pkt_cnt delta, drop_cnt delta
    tbl.push_back('{1, 3, 1, 1, 2, 1, 0});
    tbl.push_back('{0, 4, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 2, 0, 0, 0, 1});
    tbl.push_back('{1, 5, 7, 1, 1, 1, 0});
    tbl.push_back('{1, 2, 3, 1, 0, 1, 0});
    tbl.push_back('{1, 6, 0, 1, 6, 1, 0});
    tbl.push_back('{1, 1, 1, 1, 0, 1, 0});
    foreach (tbl[i]) begin
      hdr_seen = 0; beat_seen = 0; noc_seen = 0;
      p0 = pkt_cnt; d0 = drop_cnt;
      add_pkt(tbl[i].ok, tbl[i].len, tbl[i].meta);
      run_idle($sformatf("v%0d", i), 200);
      chk($sformatf("v%0d_hdrs", i), 64'(hdr_seen), 64'(tbl[i].hdrs));
      chk($sformatf("v%0d_beats", i), 64'(beat_seen), 64'(tbl[i].beats));
      chk($sformatf("v%0d_flits", i), 64'(noc_seen), 64'(1 + tbl[i].len));
      chk($sformatf("v%0d_pkt", i), 64'(pkt_cnt - p0), 64'(tbl[i].dpkt));
      chk($sformatf("v%0d_drop", i), 64'(drop_cnt - d0), 64'(tbl[i].ddrop));
    end

    // Zero-length packet: next header taken the cycle after the record.
    noc_cyc.delete(); hdr_cyc.delete();
    add_pkt(1, 0, 0); add_pkt(1, 0, 0);
    run_idle("len0", 50);
    chk("len0_next_hdr",
        64'((noc_cyc.size() > 1 && hdr_cyc.size() > 0) ? noc_cyc[1] - hdr_cyc[0] : -1), 64'd1);
    chk("hdr_latency", 64'((hdr_cyc.size() > 0) ? hdr_cyc[0] - noc_cyc[0] : -1), 64'd1);

    // Back-to-back: header right after the last payload flit.
    noc_cyc.delete(); hdr_cyc.delete();
    add_pkt(1, 2, 0); add_pkt(1, 0, 0);
    run_idle("b2b", 50);
    chk("b2b_gap", 64'((noc_cyc.size() > 3) ? noc_cyc[3] - noc_cyc[2] : -1), 64'd1);

    // Reset in the middle of a payload.
    beat_seen = 0;
    add_pkt(1, 5, 0);
    for (int n = 0; n < 50 && beat_seen < 2; n++) step();
    chk("mid_reached", 64'(beat_seen), 64'd2);
    do_reset("mid", 1);
    add_pkt(1, 3, 1);
    run_idle("after_rst", 100);
    chk("after_rst_pkt", 64'(pkt_cnt), 64'd1);

    // Random traffic with stalls on every interface.
    do_reset("rnd", 1);
    val_pct = 70; hrdy_pct = 50; drdy_pct = 50;
    for (int i = 0; i < 100; i++) add_pkt(1, $urandom_range(20), $urandom_range(6));
    run_idle("rnd", 20000);
    chk("rnd_pkt", 64'(pkt_cnt), 64'd100);
    chk("rnd_drop", 64'(drop_cnt), 64'd0);

    // Counter wrap.
    val_pct = 100; hrdy_pct = 100; drdy_pct = 100;
    @(negedge clk);
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_cnt_q;
    add_pkt(1, 2, 0);
    run_idle("wrap", 50);
    chk("pkt_wrap", 64'(pkt_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
